// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, default
// latencies and FSM state encoding.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int unsigned MD_MULT_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the {hi, lo} pair and a
// divide-by-zero flag. Holds no state.
module md_arith
  import md_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_bu;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] sq_mag;
  logic        [31:0] sr_mag;
  logic        [31:0] sq;
  logic        [31:0] sr;
  logic               b_zero;

  assign b_zero = (b == 32'd0);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on zero so the datapath never evaluates x/0; the
  // controller suppresses the commit via div_zero.
  assign div_bu = b_zero ? 32'd1 : b;
  assign uq     = a / div_bu;
  assign ur     = a % div_bu;

  // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000 unsigned,
  // so the -1 overflow case falls out as q = 0x80000000, r = 0.
  assign mag_a  = a[31] ? (32'd0 - a) : a;
  assign mag_b  = b_zero ? 32'd1 : (b[31] ? (32'd0 - b) : b);
  assign sq_mag = mag_a / mag_b;
  assign sr_mag = mag_a % mag_b;
  assign sq     = (a[31] ^ b[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr     = a[31] ? (32'd0 - sr_mag) : sr_mag;

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result   = {sr, sq};
        div_zero = b_zero;
      end
      MD_DIVU: begin
        result   = {ur, uq};
        div_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Execute-stage multiply/divide sequencer: owns HI/LO, holds results back for
// the architectural latency and requests decode stalls while busy.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MultCnt = 4'(MULT_LAT - 1);
  localparam logic [3:0] DivCnt  = 4'(DIV_LAT - 1);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [31:0] p_hi_q;
  logic [31:0] p_lo_q;
  logic        p_dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] arith_res;
  logic        arith_dz;
  logic        arith_start;

  md_arith u_arith (
    .op       (md_op),
    .a        (src_a),
    .b        (src_b),
    .result   (arith_res),
    .div_zero (arith_dz)
  );

  assign arith_start = start & ~flush & ~md_op[2];

  assign busy      = (state_q == MD_RUN);
  assign stall_req = d_md_use & (busy | arith_start);
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_dz_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start && !flush) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                {p_hi_q, p_lo_q} <= arith_res;
                p_dz_q           <= arith_dz;
                cnt_q            <= MultCnt;
                state_q          <= MD_RUN;
              end
              MD_DIV, MD_DIVU: begin
                {p_hi_q, p_lo_q} <= arith_res;
                p_dz_q           <= arith_dz;
                cnt_q            <= DivCnt;
                state_q          <= MD_RUN;
              end
              MD_MTHI: hi_q <= src_a;
              MD_MTLO: lo_q <= src_a;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          // Flush wins over a same-cycle commit: the aborted result never lands.
          if (flush) begin
            state_q <= MD_IDLE;
          end else if (cnt_q == 4'd0) begin
            if (!p_dz_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: latency, arithmetic corner cases,
// flush abort, stall request and asynchronous reset.
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_md_use;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  md_ctrl #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_md_use  (d_md_use),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current cycle T, then return in cycle T+1 with start low.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    #1;
  endtask

  // Called in cycle T+1; checks busy for n cycles, returns in T+n+1.
  task automatic expect_busy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, {31'd0, busy}, 32'd1);
      tick();
      #1;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    md_op       = 3'd0;
    src_a       = 32'd0;
    src_b       = 32'd0;
    d_md_use    = 1'b1;
    flush       = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    tick();
    reset    = 1'b1;
    d_md_use = 1'b0;
    tick();

    // mult -2 * 3: busy T+1..T+5, result from T+6
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      check("mult_busy", {31'd0, busy}, 32'd1);
      if (i == 5) check("mult_hi_hold", hi, 32'd0);
      tick();
      #1;
    end
    check("mult_busy_end", {31'd0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // divu 100/7 back-to-back, with a D-stage md instruction waiting
    d_md_use = 1'b1;
    start    = 1'b1;
    md_op    = 3'd3;
    src_a    = 32'd100;
    src_b    = 32'd7;
    #1;
    check("divu_stall_T", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0;
    #1;
    for (int i = 1; i <= 10; i++) begin
      check("divu_busy", {31'd0, busy}, 32'd1);
      check("divu_stall", {31'd0, stall_req}, 32'd1);
      tick();
      #1;
    end
    check("divu_busy_end", {31'd0, busy}, 32'd0);
    check("divu_stall_end", {31'd0, stall_req}, 32'd0);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    d_md_use = 1'b0;

    // signed div -7/2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    expect_busy("div_busy", 10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // mthi / mtlo preload, then divide by zero leaves them untouched
    issue(3'd4, 32'h0000_1111, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h0000_1111);
    issue(3'd5, 32'h0000_2222, 32'd0);
    check("mtlo_lo", lo, 32'h0000_2222);
    check("mtlo_hi", hi, 32'h0000_1111);
    issue(3'd2, 32'd5, 32'd0);
    expect_busy("dz_busy", 10);
    check("dz_hi", hi, 32'h0000_1111);
    check("dz_lo", lo, 32'h0000_2222);

    // signed overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_busy("ovf_busy", 10);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);

    // multu max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_busy("multu_busy", 5);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // reserved op: nothing happens
    issue(3'd6, 32'h1234_5678, 32'd9);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, 32'hFFFF_FFFE);

    // mult 3*4 aborted by flush in T+3
    issue(3'd0, 32'd3, 32'd4);
    check("fl_busy1", {31'd0, busy}, 32'd1);
    tick();
    check("fl_busy2", {31'd0, busy}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    check("fl_busy3", {31'd0, busy}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check("fl_busy4", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("fl_hi", hi, 32'hFFFF_FFFE);
    check("fl_lo", lo, 32'h0000_0001);

    // start coincident with flush is dropped, including mthi
    flush    = 1'b1;
    d_md_use = 1'b1;
    start    = 1'b1;
    md_op    = 3'd0;
    src_a    = 32'd7;
    src_b    = 32'd7;
    #1;
    check("flst_stall", {31'd0, stall_req}, 32'd0);
    tick();
    check("flst_busy", {31'd0, busy}, 32'd0);
    md_op = 3'd4;
    src_a = 32'hDEAD_BEEF;
    tick();
    start    = 1'b0;
    flush    = 1'b0;
    d_md_use = 1'b0;
    #1;
    check("flmthi_hi", hi, 32'hFFFF_FFFE);

    // asynchronous reset mid-div
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    check("ar_busy_pre", {31'd0, busy}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_hi", hi, 32'd0);
    check("ar_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    issue(3'd5, 32'h0000_ABCD, 32'd0);
    check("ar_mtlo", lo, 32'h0000_ABCD);
    check("ar_hi_after", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
